instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_if.sv | 38 +++
 rtl/instr_fetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - control, program-load and fetch-output bundle of instr_fetch
//
// Signals:
//   start       one-cycle request to begin execution from address 0
//   stall       freezes sequencing while high
//   load_we     program memory write strobe (honoured only while not running)
//   load_addr   program memory write address (ADDR_W bits)
//   load_data   instruction word to store (8 bits)
//   instr       registered instruction for the downstream processor
//   instr_valid instr carries a fetched instruction
//   pc          address of the next word to fetch
//   busy        fetch unit is in RUN
//   halted      fetch unit is in HALTED
// Modports: master drives control/load and observes outputs; slave is the fetch unit.
interface instr_fetch_if #(
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic              stall;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic [7:0]        instr;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport master (
        output start, stall, load_we, load_addr, load_data,
        input  instr, instr_valid, pc, busy, halted
    );

    modport slave (
        input  start, stall, load_we, load_addr, load_data,
        output instr, instr_valid, pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - sequential instruction fetch unit with loadable program memory
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (program memory is not affected)
//   bus    instr_fetch_if.slave: start/stall/load_* in, instr/instr_valid/pc/busy/halted out
// Parameters:
//   ADDR_W     pc width; program memory holds 2^ADDR_W bytes
//   NOP_CODE   opcode presented on instr when nothing valid is fetched
//   HALT_CODE  opcode that stops sequencing
module instr_fetch #(
    parameter int          ADDR_W    = 4,
    parameter logic [7:0]  NOP_CODE  = 8'hFF,
    parameter logic [7:0]  HALT_CODE = 8'h13
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Contents start as NOP and survive reset, so no reset branch on the array.
    logic [7:0] mem [DEPTH] = '{default: NOP_CODE};

    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        instr_q;
    logic              valid_q;

    logic [7:0] fetch_word;
    logic       is_halt;

    logic busy_o;
    logic halted_o;
    logic fetch_en;
    logic parked;
    logic restart;
    logic load_en;

    assign fetch_word = mem[pc_q];
    assign is_halt    = (fetch_word == HALT_CODE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_RUN;
            S_RUN:    if (!bus.stall && is_halt) state_nxt = S_HALTED;
            S_HALTED: if (bus.start) state_nxt = S_RUN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        busy_o   = 1'b0;
        halted_o = 1'b0;
        fetch_en = 1'b0;
        parked   = 1'b0;
        restart  = 1'b0;
        load_en  = 1'b0;
        case (state)
            S_RUN: begin
                busy_o   = 1'b1;
                fetch_en = !bus.stall;
            end
            S_HALTED: begin
                halted_o = 1'b1;
                parked   = 1'b1;
                restart  = bus.start;
                load_en  = bus.load_we;
            end
            default: begin
                parked   = 1'b1;
                restart  = bus.start;
                load_en  = bus.load_we;
            end
        endcase
    end

    // Fetch datapath. A HALT word is still emitted as valid, but pc stays
    // pointing at it so the halted pc identifies where execution stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= NOP_CODE;
            valid_q <= 1'b0;
        end else if (fetch_en) begin
            instr_q <= fetch_word;
            valid_q <= 1'b1;
            if (!is_halt) begin
                pc_q <= pc_q + 1'b1;
            end
        end else if (parked) begin
            instr_q <= NOP_CODE;
            valid_q <= 1'b0;
            if (restart) begin
                pc_q <= '0;
            end
        end
    end

    // Loads are only accepted while parked, so a write never races a fetch.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_o;
    assign bus.halted      = halted_o;

endmodule
